// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V pipeline.
// Forwarding, load-use stall, branch flush, mul/div wait with watchdog, stats.
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             MemtoRegE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MulDivStartE,
    input  logic             MulDivDone,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushF,
    output logic             FlushBranch,
    output logic             FlushLoad,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MdTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int MDW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

    typedef enum logic {
        RUN,
        MDWAIT
    } state_t;

    state_t         state;
    state_t         stateNext;
    logic [MDW-1:0] mdCnt;
    logic           loadUse;
    logic           mdExpire;

    // Operand forwarding: MEM result is newer than WB, x0 never forwards
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && RD_M != 5'd0 && RD_M == RS1_E)
            ForwardAE = 2'b10;
        else if (RegWriteW && RD_W != 5'd0 && RD_W == RS1_E)
            ForwardAE = 2'b01;
        if (RegWriteM && RD_M != 5'd0 && RD_M == RS2_E)
            ForwardBE = 2'b10;
        else if (RegWriteW && RD_W != 5'd0 && RD_W == RS2_E)
            ForwardBE = 2'b01;
    end

    assign loadUse = MemtoRegE && RD_E != 5'd0 &&
                     (RD_E == RS1_D || RD_E == RS2_D);
    assign mdExpire = (mdCnt == MDW'(MD_TIMEOUT - 1));

    // Next-state and stall/flush outputs; branch outranks load-use
    always_comb begin
        stateNext   = state;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        FlushF      = 1'b0;
        FlushBranch = 1'b0;
        FlushLoad   = 1'b0;
        FlushM      = 1'b0;
        case (state)
            RUN: begin
                if (PCSrcE) begin
                    FlushF      = 1'b1;
                    FlushBranch = 1'b1;
                end else begin
                    if (loadUse) begin
                        StallF    = 1'b1;
                        StallD    = 1'b1;
                        FlushLoad = 1'b1;
                    end
                    if (MulDivStartE)
                        stateNext = MDWAIT;
                end
            end
            MDWAIT: begin
                if (MulDivDone) begin
                    stateNext = RUN;
                end else begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                    if (mdExpire)
                        stateNext = RUN;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    // State, wait counter, sticky watchdog flag and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            mdCnt      <= '0;
            MdTimeout  <= 1'b0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            state <= stateNext;
            if (state == RUN)
                mdCnt <= '0;
            else
                mdCnt <= mdCnt + MDW'(1);
            if (state == MDWAIT && !MulDivDone && mdExpire)
                MdTimeout <= 1'b1;
            if (StallF && StallCount != '1)
                StallCount <= StallCount + CNT_W'(1);
            if (FlushBranch && FlushCount != '1)
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// Directed plan sequences then randomized traffic against a cycle model.
module tb_pipeline_hazard_ctrl;

    localparam int MDTO = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic          MemtoRegE, RegWriteM, RegWriteW;
    logic          PCSrcE, MulDivStartE, MulDivDone;
    logic          StallF, StallD, StallE, FlushF;
    logic          FlushBranch, FlushLoad, FlushM, MdTimeout;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] StallCount, FlushCount;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(MDTO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MulDivStartE(MulDivStartE), .MulDivDone(MulDivDone),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushF(FlushF), .FlushBranch(FlushBranch),
        .FlushLoad(FlushLoad), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdTimeout(MdTimeout),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       mem2reg, rwm, rww, pc, start, done;
    } stim_t;

    typedef struct {
        logic [11:0] flags;
        int          sc;
        int          fc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;

    // reference model state (plain counters, 1-based wait cycle index)
    bit busy;
    int waitIdx;
    bit tmo;
    int sc;
    int fc;

    function automatic stim_t z();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic logic [1:0] fwd(input stim_t s, input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (s.rwm && s.rdm == rs) return 2'b10;
        if (s.rww && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic modelReset();
        busy = 0; waitIdx = 0; tmo = 0; sc = 0; fc = 0;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        bit sf, se, ff, fb, fl, fm, lu;
        bit nBusy, nTmo;
        int nIdx;
        @(posedge clk);
        #1;
        cycle++;
        rst = s.rst;
        RS1_D = s.rs1d; RS2_D = s.rs2d;
        RS1_E = s.rs1e; RS2_E = s.rs2e;
        RD_E = s.rde; RD_M = s.rdm; RD_W = s.rdw;
        MemtoRegE = s.mem2reg; RegWriteM = s.rwm; RegWriteW = s.rww;
        PCSrcE = s.pc; MulDivStartE = s.start; MulDivDone = s.done;
        sf = 0; se = 0; ff = 0; fb = 0; fl = 0; fm = 0;
        nBusy = busy; nIdx = waitIdx; nTmo = tmo;
        lu = s.mem2reg && s.rde != 0 &&
             (s.rde == s.rs1d || s.rde == s.rs2d);
        if (busy) begin
            if (s.done) begin
                nBusy = 0;
            end else begin
                sf = 1; se = 1; fm = 1;
                if (waitIdx == MDTO) begin
                    nBusy = 0;
                    nTmo = 1;
                end else begin
                    nIdx = waitIdx + 1;
                end
            end
        end else if (s.pc) begin
            ff = 1; fb = 1;
        end else begin
            if (lu) begin
                sf = 1; fl = 1;
            end
            if (s.start) begin
                nBusy = 1;
                nIdx = 1;
            end
        end
        e.flags = {sf, sf, se, ff, fb, fl, fm,
                   fwd(s, s.rs1e), fwd(s, s.rs2e), tmo};
        e.sc = sc;
        e.fc = fc;
        e.cyc = cycle;
        q.push_back(e);
        if (s.rst) begin
            modelReset();
        end else begin
            if (sf) sc = (sc < CMAX) ? sc + 1 : CMAX;
            if (fb) fc = (fc < CMAX) ? fc + 1 : CMAX;
            busy = nBusy; waitIdx = nIdx; tmo = nTmo;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(z());
    endtask

    task automatic check(input string nm, input int cyc,
                         input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // monitor: every cycle the DUT presents a response, pop and compare
    initial begin
        exp_t e;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                act = {StallF, StallD, StallE, FlushF, FlushBranch,
                       FlushLoad, FlushM, ForwardAE, ForwardBE, MdTimeout};
                check("flags", e.cyc, int'(act), int'(e.flags));
                check("stallcnt", e.cyc, int'(StallCount), e.sc);
                check("flushcnt", e.cyc, int'(FlushCount), e.fc);
            end
        end
    end

    initial begin
        stim_t s;
        int guard;
        rst = 1'b1;
        RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0;
        RD_E = 0; RD_M = 0; RD_W = 0;
        MemtoRegE = 0; RegWriteM = 0; RegWriteW = 0;
        PCSrcE = 0; MulDivStartE = 0; MulDivDone = 0;
        repeat (2) @(posedge clk);
        modelReset();
        s = z(); s.rst = 1; step(s);
        idle(1);
        // forwarding priority and x0
        s = z(); s.rs1e = 5; s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1;
        s.rs2e = 5; step(s);
        s.rwm = 0; step(s);
        s.rs1e = 0; s.rwm = 1; step(s);
        // load-use, then released, then x0 load
        s = z(); s.mem2reg = 1; s.rde = 7; s.rs2d = 7; step(s);
        idle(1);
        s.rde = 0; s.rs2d = 0; step(s);
        // branch beats load-use
        s = z(); s.mem2reg = 1; s.rde = 7; s.rs1d = 7; s.pc = 1; step(s);
        // branch and start together: no transition
        s = z(); s.pc = 1; s.start = 1; step(s);
        idle(1);
        // mul/div done on 4th wait cycle
        s = z(); s.start = 1; step(s);
        idle(3);
        s = z(); s.done = 1; step(s);
        idle(2);
        // watchdog expiry, then done exactly on the last cycle
        s = z(); s.start = 1; step(s);
        idle(MDTO + 2);
        s = z(); s.rst = 1; step(s);
        s = z(); s.start = 1; step(s);
        idle(MDTO - 1);
        s = z(); s.done = 1; step(s);
        idle(2);
        // reset in the middle of a wait
        s = z(); s.start = 1; step(s);
        idle(2);
        s = z(); s.rst = 1; step(s);
        idle(2);
        // saturation: long stalls without done
        for (int k = 0; k < 3; k++) begin
            s = z(); s.start = 1; step(s);
            idle(MDTO);
        end
        idle(1);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s = z();
            s.rst = ($urandom_range(0, 299) == 0);
            s.rs1d = 5'($urandom_range(0, 3));
            s.rs2d = 5'($urandom_range(0, 3));
            s.rs1e = 5'($urandom_range(0, 3));
            s.rs2e = 5'($urandom_range(0, 3));
            s.rde = 5'($urandom_range(0, 3));
            s.rdm = 5'($urandom_range(0, 3));
            s.rdw = 5'($urandom_range(0, 3));
            s.mem2reg = ($urandom_range(0, 2) == 0);
            s.rwm = 1'($urandom_range(0, 1));
            s.rww = 1'($urandom_range(0, 1));
            s.pc = ($urandom_range(0, 7) == 0);
            s.start = ($urandom_range(0, 9) == 0);
            s.done = ($urandom_range(0, 9) == 0);
            step(s);
        end
        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
